// File: rtl/add_serial_w_if.sv
// ---------------------------------------------------------------------------
// add_serial_w_if : operand/result handshake bundle for add_serial_w.
//
//   in_valid / in_ready   : operand request handshake (master -> slave)
//   sub, cin, a, b        : operation select, carry/borrow-in, operands
//   out_valid / out_ready : result handshake (slave -> master)
//   res, cout, ovf, zero  : sum/difference and flags
//
// master : the requester (drives operands, consumes results)
// slave  : the adder (accepts operands, produces results)
// ---------------------------------------------------------------------------
interface add_serial_w_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic             sub;
  logic             cin;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] res;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, sub, cin, a, b, out_ready,
    input  in_ready, out_valid, res, cout, ovf, zero
  );

  modport slave (
    input  in_valid, sub, cin, a, b, out_ready,
    output in_ready, out_valid, res, cout, ovf, zero
  );
endinterface

// File: rtl/add_serial_w.sv
// ---------------------------------------------------------------------------
// add_serial_w : multi-cycle adder/subtractor.
//
// A CHUNK-bit ripple slice is reused WIDTH/CHUNK times, so one operation
// takes N = WIDTH/CHUNK RUN cycles. Computes
//   {cout, res} = a + (sub ? ~b : b) + (cin ^ sub)
// and reports signed overflow and a zero flag.
//
// Ports:
//   clk   : clock, all state updates on the rising edge
//   rst_n : synchronous reset, active-low
//   bus   : add_serial_w_if.slave
//             in_valid/in_ready, sub, cin, a, b   (operand side)
//             out_valid/out_ready, res, cout, ovf, zero (result side)
//
// Operation flow: IDLE (in_ready=1) -> accept -> RUN (N cycles) ->
// DONE (out_valid=1, outputs held) -> out_ready -> IDLE.
// ---------------------------------------------------------------------------
module add_serial_w #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  add_serial_w_if.slave bus
);

  localparam int N     = WIDTH / CHUNK;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_carry;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic             r_cout;
  logic             r_ovf;
  logic             r_zero;

  logic             w_in_ready;
  logic             w_accept;
  logic             w_last;
  logic [CHUNK-1:0] w_a_chk;
  logic [CHUNK-1:0] w_b_chk;
  logic [CHUNK:0]   w_sum;
  logic [WIDTH-1:0] w_res_next;

  // Ready is forced low while reset is held so nothing is accepted during it.
  assign w_in_ready = rst_n && (r_state == S_IDLE);
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_last     = (r_cnt == CNT_LAST);

  // Operands are shifted right one chunk per RUN cycle, so the active chunk
  // is always the low CHUNK bits. On the last cycle the low chunk is the
  // top chunk, which is where the sign bits for overflow come from.
  assign w_a_chk = r_a[CHUNK-1:0];
  assign w_b_chk = r_b[CHUNK-1:0];
  assign w_sum   = {1'b0, w_a_chk} + {1'b0, w_b_chk} + {{CHUNK{1'b0}}, r_carry};

  // Result fills from the top: each new chunk enters at the MSB end and the
  // earlier chunks move down, landing in place after N cycles.
  assign w_res_next = (r_res >> CHUNK) | (WIDTH'(w_sum[CHUNK-1:0]) << (WIDTH - CHUNK));

  // ---- control and result registers ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_res   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_zero  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_carry <= bus.cin ^ bus.sub;
            r_cnt   <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_res   <= w_res_next;
          r_carry <= w_sum[CHUNK];
          r_cnt   <= r_cnt + 1'b1;
          if (w_last) begin
            r_cout  <= w_sum[CHUNK];
            r_ovf   <= (w_a_chk[CHUNK-1] == w_b_chk[CHUNK-1]) &&
                       (w_sum[CHUNK-1] != w_a_chk[CHUNK-1]);
            r_zero  <= (w_res_next == '0);
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // ---- operand registers (captured at accept, consumed chunk by chunk) ----
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_a <= bus.a;
      r_b <= bus.sub ? ~bus.b : bus.b;
    end else if (r_state == S_RUN) begin
      r_a <= r_a >> CHUNK;
      r_b <= r_b >> CHUNK;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.res       = r_res;
  assign bus.cout      = r_cout;
  assign bus.ovf       = r_ovf;
  assign bus.zero      = r_zero;

endmodule

// File: tb/tb_add_serial_w.sv
module tb_add_serial_w;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // Bench-side drivers, one slot per DUT instance.
  logic        d_valid [4];
  logic        d_sub   [4];
  logic        d_cin   [4];
  logic        d_ordy  [4];
  logic [31:0] d_a     [4];
  logic [31:0] d_b     [4];

  add_serial_w_if #(.WIDTH(32)) if0 ();
  add_serial_w_if #(.WIDTH(32)) if1 ();
  add_serial_w_if #(.WIDTH(32)) if2 ();
  add_serial_w_if #(.WIDTH(8))  if3 ();

`define HOOK(IFN, K, W) \
  assign IFN.in_valid  = d_valid[K]; \
  assign IFN.sub       = d_sub[K]; \
  assign IFN.cin       = d_cin[K]; \
  assign IFN.out_ready = d_ordy[K]; \
  assign IFN.a         = d_a[K][W-1:0]; \
  assign IFN.b         = d_b[K][W-1:0];

  `HOOK(if0, 0, 32)
  `HOOK(if1, 1, 32)
  `HOOK(if2, 2, 32)
  `HOOK(if3, 3, 8)

  add_serial_w #(.WIDTH(32), .CHUNK(4))  u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  add_serial_w #(.WIDTH(32), .CHUNK(32)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  add_serial_w #(.WIDTH(32), .CHUNK(1))  u2 (.clk(clk), .rst_n(rst_n), .bus(if2));
  add_serial_w #(.WIDTH(8),  .CHUNK(2))  u3 (.clk(clk), .rst_n(rst_n), .bus(if3));

  typedef struct packed {
    logic        irdy;
    logic        ovld;
    logic        cout;
    logic        ovf;
    logic        zero;
    logic [31:0] res;
  } mon_t;

  function automatic mon_t mon(input int k);
    mon_t m;
    m = '0;
    case (k)
      0: begin m.irdy = if0.in_ready; m.ovld = if0.out_valid; m.cout = if0.cout;
               m.ovf = if0.ovf; m.zero = if0.zero; m.res = if0.res; end
      1: begin m.irdy = if1.in_ready; m.ovld = if1.out_valid; m.cout = if1.cout;
               m.ovf = if1.ovf; m.zero = if1.zero; m.res = if1.res; end
      2: begin m.irdy = if2.in_ready; m.ovld = if2.out_valid; m.cout = if2.cout;
               m.ovf = if2.ovf; m.zero = if2.zero; m.res = if2.res; end
      default: begin m.irdy = if3.in_ready; m.ovld = if3.out_valid; m.cout = if3.cout;
               m.ovf = if3.ovf; m.zero = if3.zero; m.res = 32'(if3.res); end
    endcase
    return m;
  endfunction

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp)
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    else
      n_pass++;
  endtask

  // Reference model: independent wide-integer arithmetic.
  task automatic ref_calc(input int w, input logic [31:0] a, input logic [31:0] b,
                          input logic sub, input logic cin,
                          output logic [31:0] res, output logic cout,
                          output logic ovf, output logic zero);
    logic [63:0] m, ae, be, s;
    m    = (64'd1 << w) - 64'd1;
    ae   = {32'h0, a} & m;
    be   = (sub ? ~{32'h0, b} : {32'h0, b}) & m;
    s    = ae + be + 64'(cin ^ sub);
    res  = 32'(s & m);
    cout = s[w];
    ovf  = (ae[w-1] == be[w-1]) && (s[w-1] != ae[w-1]);
    zero = (res == 32'h0);
  endtask

  task automatic start(input int k, input logic [31:0] a, input logic [31:0] b,
                       input logic sub, input logic cin);
    @(negedge clk);
    d_valid[k] = 1'b1; d_a[k] = a; d_b[k] = b; d_sub[k] = sub; d_cin[k] = cin;
    @(posedge clk);
    #1;
    d_valid[k] = 1'b0;
  endtask

  task automatic wait_done(input int k, output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!mon(k).ovld && lat < 200);
  endtask

  task automatic consume(input int k);
    @(negedge clk);
    d_ordy[k] = 1'b1;
    @(posedge clk);
    #1;
    d_ordy[k] = 1'b0;
  endtask

  task automatic do_op(input int k, input logic [31:0] a, input logic [31:0] b,
                       input logic sub, input logic cin, output mon_t r, output int lat);
    start(k, a, b, sub, cin);
    wait_done(k, lat);
    r = mon(k);
    consume(k);
  endtask

  typedef struct {
    logic [31:0] a, b;
    logic        sub, cin;
    logic [31:0] r;
    logic        c, o, z;
  } vec_t;

  vec_t vecs [8];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    mon_t r;
    int   lat;
    logic [31:0] er;
    logic ec, eo, ez;

    for (int i = 0; i < 4; i++) begin
      d_valid[i] = 1'b0; d_sub[i] = 1'b0; d_cin[i] = 1'b0; d_ordy[i] = 1'b0;
      d_a[i] = '0; d_b[i] = '0;
    end

    vecs[0] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1};
    vecs[1] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{32'h7FFFFFFF, 32'h00000000, 1'b0, 1'b1, 32'h80000000, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{32'h00000005, 32'h00000007, 1'b1, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{32'h80000000, 32'h00000001, 1'b1, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{32'h00000009, 32'h00000004, 1'b1, 1'b1, 32'h00000004, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{32'h12345678, 32'h11111111, 1'b0, 1'b0, 32'h23456789, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{32'hA5A5A5A5, 32'hA5A5A5A5, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1};

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst.in_ready", 64'(mon(0).irdy), 64'd0);
    check("rst.out_valid", 64'(mon(0).ovld), 64'd0);
    check("rst.res", 64'(mon(0).res), 64'd0);
    check("rst.flags", 64'({mon(0).cout, mon(0).ovf, mon(0).zero}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rel.in_ready", 64'(mon(0).irdy), 64'd1);

    // Directed vectors, 32/4
    for (int i = 0; i < 8; i++) begin
      do_op(0, vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].cin, r, lat);
      check($sformatf("v%0d.lat", i),  64'(lat),    64'd8);
      check($sformatf("v%0d.res", i),  64'(r.res),  64'(vecs[i].r));
      check($sformatf("v%0d.cout", i), 64'(r.cout), 64'(vecs[i].c));
      check($sformatf("v%0d.ovf", i),  64'(r.ovf),  64'(vecs[i].o));
      check($sformatf("v%0d.zero", i), 64'(r.zero), 64'(vecs[i].z));
    end

    // Backpressure: result must hold while in_valid/operands churn
    start(0, 32'h0F0F0F0F, 32'h01010101, 1'b0, 1'b0);
    wait_done(0, lat);
    check("bp.lat", 64'(lat), 64'd8);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      d_valid[0] = ~d_valid[0];
      d_a[0] = $urandom; d_b[0] = $urandom; d_sub[0] = 1'($urandom); d_cin[0] = 1'($urandom);
      @(posedge clk);
      #1;
      check($sformatf("bp%0d.res", i), 64'(mon(0).res), 64'h10101010);
      check($sformatf("bp%0d.flags", i), 64'({mon(0).cout, mon(0).ovf, mon(0).zero}), 64'd0);
      check($sformatf("bp%0d.out_valid", i), 64'(mon(0).ovld), 64'd1);
      check($sformatf("bp%0d.in_ready", i), 64'(mon(0).irdy), 64'd0);
    end
    @(negedge clk);
    d_valid[0] = 1'b0;
    d_ordy[0]  = 1'b1;
    #1;
    check("bp.in_ready_same_cycle", 64'(mon(0).irdy), 64'd0);
    @(posedge clk);
    #1;
    d_ordy[0] = 1'b0;
    check("bp.in_ready_next", 64'(mon(0).irdy), 64'd1);
    check("bp.out_valid_drop", 64'(mon(0).ovld), 64'd0);
    repeat (10) @(posedge clk);
    #1;
    check("bp.no_stray_op", 64'(mon(0).ovld), 64'd0);

    // Reset on the third RUN cycle discards the operation
    start(0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid.in_ready_in_rst", 64'(mon(0).irdy), 64'd0);
    @(posedge clk);
    #1;
    check("mid.out_valid", 64'(mon(0).ovld), 64'd0);
    check("mid.res", 64'(mon(0).res), 64'd0);
    check("mid.flags", 64'({mon(0).cout, mon(0).ovf, mon(0).zero}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("mid.in_ready_rel", 64'(mon(0).irdy), 64'd1);
    repeat (10) @(posedge clk);
    #1;
    check("mid.discarded", 64'(mon(0).ovld), 64'd0);
    do_op(0, 32'd2, 32'd3, 1'b0, 1'b0, r, lat);
    check("fresh.lat", 64'(lat), 64'd8);
    check("fresh.res", 64'(r.res), 64'd5);
    check("fresh.cout", 64'(r.cout), 64'd0);

    // Parameter sweep against the reference model
    for (int k = 1; k < 4; k++) begin
      int w, n;
      w = (k == 3) ? 8 : 32;
      n = (k == 1) ? 1 : (k == 2) ? 32 : 4;
      for (int i = 0; i < 1000; i++) begin
        logic [31:0] a, b;
        logic sub, cin;
        a = $urandom; b = $urandom; sub = 1'($urandom); cin = 1'($urandom);
        if (i < 4) begin
          a = (i[0]) ? 32'hFFFFFFFF : 32'h0;
          b = (i[1]) ? 32'hFFFFFFFF : 32'h0;
        end
        if (w == 8) begin a = a & 32'hFF; b = b & 32'hFF; end
        ref_calc(w, a, b, sub, cin, er, ec, eo, ez);
        do_op(k, a, b, sub, cin, r, lat);
        check($sformatf("sw%0d.%0d.lat", k, i),  64'(lat),    64'(n));
        check($sformatf("sw%0d.%0d.res", k, i),  64'(r.res),  64'(er));
        check($sformatf("sw%0d.%0d.cout", k, i), 64'(r.cout), 64'(ec));
        check($sformatf("sw%0d.%0d.ovf", k, i),  64'(r.ovf),  64'(eo));
        check($sformatf("sw%0d.%0d.zero", k, i), 64'(r.zero), 64'(ez));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
